// File: rtl/lvt_pkg.sv
// lvt_pkg
// Shared definitions for the LVT write-port arbiter slice.
//   - DEFAULT_* constants : default geometry of the memory behind the arbiter
//   - addr_t / data_t     : word address and data types at the default geometry
//   - rot_idx()           : rotate an offset around a base index modulo n
package lvt_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 512;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_AW-1:0]    addr_t;
    typedef logic [DEFAULT_WIDTH-1:0] data_t;

    // Returns (base + off) mod n. Callers always pass base < n and off <= n,
    // so the sum is below 2n and a single conditional subtract is an exact
    // modulo without needing a divider.
    function automatic int unsigned rot_idx(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        int unsigned sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/lvt_grant_select.sv
// lvt_grant_select
// Combinational grant selection over requesters already rotated so that
// position 0 is the current round-robin head. Positions are scanned in
// increasing order; a valid position is granted while ports remain and its
// address does not match any address granted earlier in the same scan.
// Ports:
//   rot_valid   - valid bits, rotated (position 0 = head)
//   rot_addr    - addresses, rotated the same way
//   grant_mask  - granted positions (rotated numbering)
//   port_used   - port k carries a grant this cycle
//   port_src    - rotated position feeding port k
//   grant_count - number of grants issued
//   any_skip    - some valid position was refused (conflict or no port left)
//   first_skip  - first refused position in scan order
//   any_grant   - at least one grant issued
//   last_grant  - last granted position in scan order
module lvt_grant_select
    import lvt_pkg::*;
#(
    parameter  int REQS  = 8,
    parameter  int PORTS = 4,
    parameter  int AW    = 9,
    localparam int IW    = (REQS > 1) ? $clog2(REQS) : 1,
    localparam int CW    = $clog2(PORTS + 1)
) (
    input  logic [REQS-1:0]           rot_valid,
    input  logic [REQS-1:0][AW-1:0]   rot_addr,
    output logic [REQS-1:0]           grant_mask,
    output logic [PORTS-1:0]          port_used,
    output logic [PORTS-1:0][IW-1:0]  port_src,
    output logic [CW-1:0]             grant_count,
    output logic                      any_skip,
    output logic [IW-1:0]             first_skip,
    output logic                      any_grant,
    output logic [IW-1:0]             last_grant
);

    logic [CW-1:0] cnt;
    logic          conflict;

    // Sequential scan unrolled into a priority chain. The running count cnt
    // doubles as the port number the next grant lands on, so the k-th grant
    // in scan order always drives port k.
    always_comb begin
        grant_mask  = '0;
        port_used   = '0;
        port_src    = '0;
        any_skip    = 1'b0;
        first_skip  = '0;
        any_grant   = 1'b0;
        last_grant  = '0;
        cnt         = '0;
        conflict    = 1'b0;

        for (int i = 0; i < REQS; i++) begin
            if (rot_valid[i]) begin
                conflict = 1'b0;
                for (int j = 0; j < REQS; j++) begin
                    if (j < i && grant_mask[j] && rot_addr[j] == rot_addr[i]) begin
                        conflict = 1'b1;
                    end
                end

                if (cnt < CW'(PORTS) && !conflict) begin
                    grant_mask[i] = 1'b1;
                    for (int p = 0; p < PORTS; p++) begin
                        if (CW'(p) == cnt) begin
                            port_used[p] = 1'b1;
                            port_src[p]  = IW'(i);
                        end
                    end
                    cnt        = cnt + 1'b1;
                    any_grant  = 1'b1;
                    last_grant = IW'(i);
                end else if (!any_skip) begin
                    any_skip   = 1'b1;
                    first_skip = IW'(i);
                end
            end
        end

        grant_count = cnt;
    end

endmodule

// File: rtl/lvt_write_arbiter.sv
// lvt_write_arbiter
// Round-robin scheduler sharing PORTS memory write ports among REQS
// requesters. Never issues two writes to the same address in one cycle.
// Granted requests are registered onto the memory port arrays, port k
// carrying the k-th grant of the cycle.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   req_valid   - per-requester request pending (held until req_ready)
//   req_addr    - per-requester write address
//   req_data    - per-requester write data
//   req_ready   - per-requester combinational grant
//   mem_addr    - registered per-port address to the memory
//   mem_en      - registered per-port write enable
//   mem_d       - registered per-port write data
//   grant_cnt   - registered number of grants issued in the previous cycle
module lvt_write_arbiter
    import lvt_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int PORTS = 4,
    parameter  int REQS  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int IW    = (REQS > 1) ? $clog2(REQS) : 1,
    localparam int CW    = $clog2(PORTS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQS-1:0]              req_valid,
    input  logic [REQS-1:0][AW-1:0]      req_addr,
    input  logic [REQS-1:0][WIDTH-1:0]   req_data,
    output logic [REQS-1:0]              req_ready,
    output logic [PORTS-1:0][AW-1:0]     mem_addr,
    output logic [PORTS-1:0]             mem_en,
    output logic [PORTS-1:0][WIDTH-1:0]  mem_d,
    output logic [CW-1:0]                grant_cnt
);

    logic [IW-1:0]                ptr;
    logic [IW-1:0]                ptr_next;

    logic [REQS-1:0]              rot_valid;
    logic [REQS-1:0][AW-1:0]      rot_addr;

    logic [REQS-1:0]              grant_mask;
    logic [PORTS-1:0]             port_used;
    logic [PORTS-1:0][IW-1:0]     port_src;
    logic [CW-1:0]                grant_count;
    logic                         any_skip;
    logic [IW-1:0]                first_skip;
    logic                         any_grant;
    logic [IW-1:0]                last_grant;

    logic [PORTS-1:0][AW-1:0]     addr_next;
    logic [PORTS-1:0][WIDTH-1:0]  data_next;

    // Map a rotated position back to an absolute requester index.
    function automatic logic [IW-1:0] abs_idx(input logic [IW-1:0] base,
                                              input int unsigned   off);
        return IW'(rot_idx(32'(base), off, REQS));
    endfunction

    // Rotate the request vectors so the selector always sees the head
    // requester at position 0.
    always_comb begin
        rot_valid = '0;
        rot_addr  = '0;
        for (int i = 0; i < REQS; i++) begin
            rot_valid[i] = req_valid[abs_idx(ptr, i)];
            rot_addr[i]  = req_addr[abs_idx(ptr, i)];
        end
    end

    lvt_grant_select #(
        .REQS  (REQS),
        .PORTS (PORTS),
        .AW    (AW)
    ) u_grant_select (
        .rot_valid   (rot_valid),
        .rot_addr    (rot_addr),
        .grant_mask  (grant_mask),
        .port_used   (port_used),
        .port_src    (port_src),
        .grant_count (grant_count),
        .any_skip    (any_skip),
        .first_skip  (first_skip),
        .any_grant   (any_grant),
        .last_grant  (last_grant)
    );

    // Un-rotate the grant mask into per-requester ready. Ready is suppressed
    // during reset so nothing handshakes in a cycle whose grants are dropped.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < REQS; i++) begin
            if (grant_mask[i] && !rst) begin
                req_ready[abs_idx(ptr, i)] = 1'b1;
            end
        end
    end

    // Port muxes: each used port pulls address and data from the requester
    // it was assigned; unused ports present zeros.
    always_comb begin
        addr_next = '0;
        data_next = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (port_used[p]) begin
                addr_next[p] = req_addr[abs_idx(ptr, 32'(port_src[p]))];
                data_next[p] = req_data[abs_idx(ptr, 32'(port_src[p]))];
            end
        end
    end

    // A skipped requester becomes the next head so it cannot be starved;
    // otherwise the head moves just past the last grant. last_grant + 1 may
    // equal REQS, which rot_idx still reduces correctly.
    always_comb begin
        ptr_next = ptr;
        if (any_skip) begin
            ptr_next = abs_idx(ptr, 32'(first_skip));
        end else if (any_grant) begin
            ptr_next = abs_idx(ptr, 32'(last_grant) + 1);
        end
    end

    // Pointer and registered memory-side outputs. Each cycle's grants are
    // presented for exactly one cycle, then replaced by the next cycle's.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            mem_en    <= '0;
            mem_addr  <= '0;
            mem_d     <= '0;
            grant_cnt <= '0;
        end else begin
            ptr       <= ptr_next;
            mem_en    <= port_used;
            mem_addr  <= addr_next;
            mem_d     <= data_next;
            grant_cnt <= grant_count;
        end
    end

endmodule
